// File: rtl/fpdp_accum_seq.sv
// ---------------------------------------------------------------------------
// fpdp_accum_seq
//
// Sums a stream of `count` IEEE-754 doubles by driving an external
// double-precision adder one element at a time. The running sum is presented
// on add_a and the new element on add_b. The final sum is published on sum_z
// together with a one-cycle sum_valid strobe. No floating-point arithmetic is
// done here; every value passes through bit-exact.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rset       asynchronous active-low reset
//   start      one-cycle request to begin; only honoured in IDLE
//   count      number of elements to sum, sampled on an accepted start
//   in_data    element to add
//   in_valid   in_data valid
//   in_ready   block can accept an element (FETCH only)
//   add_a      adder operand A (running sum)
//   add_b      adder operand B (current element)
//   add_ready  4'd1 while an add is in flight, else 4'd0
//   add_z      adder result
//   add_done   adder completion, 4'd1 means done
//   sum_z      final accumulated sum, held until overwritten
//   sum_valid  one-cycle strobe when sum_z is updated
//   busy       high in every state except IDLE
//   err        sticky adder-timeout flag, cleared on an accepted start
//   dbg_state  current FSM state, for observation only
//
// Element handshake: an element is consumed on a rising clock edge where
// in_valid and in_ready are both high; in_ready does not depend on in_valid,
// and an element presented while in_ready is low is left untouched.
// ---------------------------------------------------------------------------
module fpdp_accum_seq #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [63:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [63:0]      add_a,
    output logic [63:0]      add_b,
    output logic [3:0]       add_ready,
    input  logic [63:0]      add_z,
    input  logic [3:0]       add_done,
    output logic [63:0]      sum_z,
    output logic             sum_valid,
    output logic             busy,
    output logic             err,
    output logic [2:0]       dbg_state
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Watchdog width: enough to count 0 .. TIMEOUT-1.
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [63:0]      acc_q,   acc_d;
    logic [63:0]      opa_q,   opa_d;
    logic [63:0]      opb_q,   opb_d;
    logic [63:0]      sum_q,   sum_d;
    logic             err_q,   err_d;
    logic [WD_W-1:0]  wd_q,    wd_d;
    logic             done_q;

    // -----------------------------------------------------------------------
    // Completion detection
    // -----------------------------------------------------------------------
    // Only a rising edge of (add_done == 1) counts. done_q tracks the level
    // in every state, so a level still held from the previous add when the
    // next ISSUE begins is already "seen" and cannot complete it early.
    logic done_lvl;
    logic done_evt;
    logic wd_expired;

    assign done_lvl   = (add_done == 4'd1);
    assign done_evt   = done_lvl && !done_q;
    assign wd_expired = (wd_q == WD_LAST);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        err_d   = err_q;
        wd_d    = wd_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d = count;
                    acc_d = 64'h0;
                    err_d = 1'b0;
                    wd_d  = '0;
                    if (count == '0) begin
                        // Empty accumulation: publish +0.0 immediately.
                        sum_d   = 64'h0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                // in_ready is high for the whole state, so in_valid alone
                // completes the handshake.
                if (in_valid) begin
                    opa_d   = acc_q;
                    opb_d   = in_data;
                    wd_d    = '0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (done_evt) begin
                    acc_d   = add_z;
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = S_GAP;
                end else if (wd_expired) begin
                    // Adder never answered: drop this element, keep the
                    // running sum, and flag the loss.
                    err_d   = 1'b1;
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = S_GAP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end

            S_GAP: begin
                // One idle cycle with add_ready low lets the adder return to
                // its operand-capture state before the next request.
                if (rem_q == '0) begin
                    sum_d   = acc_q;
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            acc_q   <= 64'h0;
            opa_q   <= 64'h0;
            opb_q   <= 64'h0;
            sum_q   <= 64'h0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            done_q  <= done_lvl;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Status outputs decode the state register directly, so an asynchronous
    // reset drops add_ready, busy and sum_valid without waiting for a clock.
    assign in_ready  = (state_q == S_FETCH);
    assign add_ready = (state_q == S_ISSUE) ? 4'd1 : 4'd0;
    assign sum_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign add_a     = opa_q;
    assign add_b     = opb_q;
    assign sum_z     = sum_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fpdp_accum_seq.sv
module tb_fpdp_accum_seq;

  localparam int CNT_W = 8;
  localparam int TMO = 16;
  localparam int BUDGET = 2000;

  localparam int MODE_PULSE = 0;
  localparam int MODE_HOLD = 1;
  localparam int MODE_FIRST_ONLY = 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rset;
  always #5 clk = ~clk;

  logic start;
  logic [CNT_W-1:0] count;
  logic [63:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [63:0] add_a, add_b;
  logic [3:0] add_ready;
  logic [63:0] add_z;
  logic [3:0] add_done;
  logic [63:0] sum_z;
  logic sum_valid, busy, err;
  logic [2:0] dbg_state;

  fpdp_accum_seq #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rset(rset), .start(start), .count(count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_ready(add_ready),
    .add_z(add_z), .add_done(add_done),
    .sum_z(sum_z), .sum_valid(sum_valid), .busy(busy), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- bookkeeping
  int checks = 0;
  int failures = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [63:0] exp_q[$];      // expected sum per accumulation
  logic [127:0] op_q[$];      // expected {add_a, add_b} per issued add
  int sv_count = 0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (rset && sum_valid) begin
      sv_count++;
      if (exp_q.size() == 0) fail("unexpected_sum_valid");
      else begin
        e = exp_q.pop_front();
        check64("sum_z", sum_z, e);
      end
    end
  end

  // ---------------------------------------------------------------- adder model
  int ad_mode = MODE_PULSE;
  int ad_lat_max = 3;
  int hold_len = 8;
  int op_idx = 0;
  int issue_run = 0;
  int last_issue_len = 0;
  bit armed = 1'b1;
  bit pending = 1'b0;
  int lat_left = 0;
  int hold_left = 0;
  logic [63:0] cap_a, cap_b;

  function automatic bit completes(input int idx);
    if (ad_mode == MODE_FIRST_ONLY) return (idx == 0);
    return 1'b1;
  endfunction

  function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  always @(negedge clk) begin
    logic [127:0] op;
    if (!rset) begin
      add_done = 4'd0;
      add_z = 64'h0;
      armed = 1'b1;
      pending = 1'b0;
      hold_left = 0;
      issue_run = 0;
    end else begin
      if (add_ready == 4'd1) issue_run++;
      else if (issue_run != 0) begin
        last_issue_len = issue_run;
        issue_run = 0;
      end

      if (add_ready == 4'd0) begin
        armed = 1'b1;
        pending = 1'b0;
      end else if (armed) begin
        armed = 1'b0;
        cap_a = add_a;
        cap_b = add_b;
        if (op_q.size() == 0) fail("unexpected_add_issue");
        else begin
          op = op_q.pop_front();
          check64("add_a", add_a, op[127:64]);
          check64("add_b", add_b, op[63:0]);
        end
        pending = completes(op_idx);
        op_idx++;
        lat_left = $urandom_range(1, ad_lat_max);
      end else begin
        check64("add_a_stable", add_a, cap_a);
        check64("add_b_stable", add_b, cap_b);
      end

      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) add_done = 4'd0;
      end else if (pending) begin
        if (lat_left > 0) lat_left--;
        else if (add_done == 4'd0) begin
          add_z = fadd(cap_a, cap_b);
          add_done = 4'd1;
          pending = 1'b0;
          hold_left = (ad_mode == MODE_HOLD) ? hold_len : 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  logic [63:0] elems[256];

  task automatic feed(input logic [63:0] e, input int max_gap, input bit poke);
    int t;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    if (poke) begin
      // start while busy must be ignored
      start = 1'b1;
      count = CNT_W'($urandom_range(0, 255));
      @(negedge clk);
      start = 1'b0;
    end
    in_data = e;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) fail("in_ready_wait");
    @(negedge clk);
    in_valid = 1'b0;
    in_data = {$urandom, $urandom};
  endtask

  task automatic run_accum(input int n, input int max_gap, input bit poke,
                           input logic [63:0] exp_sum, input string name);
    int sv_before;
    int t;
    logic [63:0] acc;
    acc = 64'h0;
    op_idx = 0;
    for (int i = 0; i < n; i++) begin
      op_q.push_back({acc, elems[i]});
      if (completes(i)) acc = fadd(acc, elems[i]);
    end
    exp_q.push_back(exp_sum);
    sv_before = sv_count;
    start = 1'b1;
    count = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    count = CNT_W'($urandom_range(0, 255));
    for (int i = 0; i < n; i++) feed(elems[i], max_gap, poke);
    t = 0;
    while (sv_count == sv_before && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (sv_count == sv_before) fail({name, "_sum_valid_wait"});
    repeat (3) @(negedge clk);
    check64({name, "_pulses"}, 64'(sv_count - sv_before), 64'd1);
    check64({name, "_busy_after"}, {63'd0, busy}, 64'd0);
    check64({name, "_ops_left"}, 64'(op_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int n;
    logic [3:0][63:0] e;
    logic [63:0] exp_sum;
  } vec_t;

  vec_t vecs[5];

  // ---------------------------------------------------------------- main
  initial begin
    int sv_before;
    int n;
    real r;

    rset = 1'b0;
    start = 1'b0;
    count = '0;
    in_data = 64'h0;
    in_valid = 1'b0;

    vecs[0] = '{3, {64'h0, 64'h4008000000000000, 64'h4000000000000000, 64'h3FF0000000000000}, 64'h4018000000000000};
    vecs[1] = '{1, {64'h0, 64'h0, 64'h0, 64'hBFF0000000000000}, 64'hBFF0000000000000};
    vecs[2] = '{2, {64'h0, 64'h0, 64'hC000000000000000, 64'h4000000000000000}, 64'h0000000000000000};
    vecs[3] = '{4, {64'h3FC0000000000000, 64'h3FC0000000000000, 64'h3FD0000000000000, 64'h3FE0000000000000}, 64'h3FF0000000000000};
    vecs[4] = '{2, {64'h0, 64'h0, 64'h3FF0000000000000, 64'h7FF0000000000000}, 64'h7FF0000000000000};

    // reset state
    repeat (3) @(negedge clk);
    check64("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check64("rst_add_ready", {60'd0, add_ready}, 64'd0);
    check64("rst_busy", {63'd0, busy}, 64'd0);
    check64("rst_sum_valid", {63'd0, sum_valid}, 64'd0);
    check64("rst_err", {63'd0, err}, 64'd0);
    check64("rst_sum_z", sum_z, 64'd0);
    check64("rst_add_a", add_a, 64'd0);
    check64("rst_add_b", add_b, 64'd0);
    check64("rst_state", {61'd0, dbg_state}, 64'd0);
    rset = 1'b1;
    @(negedge clk);

    // table-driven vectors
    ad_mode = MODE_PULSE;
    ad_lat_max = 3;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) elems[i] = vecs[k].e[i];
      run_accum(vecs[k].n, 2, 1'b0, vecs[k].exp_sum, $sformatf("vec%0d", k));
    end

    // count == 0: sum_valid one cycle after start, no add issued
    op_idx = 0;
    exp_q.push_back(64'h0);
    sv_before = sv_count;
    start = 1'b1;
    count = '0;
    @(negedge clk);
    start = 1'b0;
    check64("cnt0_sum_valid", {63'd0, sum_valid}, 64'd1);
    check64("cnt0_sum_z", sum_z, 64'h0);
    @(negedge clk);
    check64("cnt0_sum_valid_low", {63'd0, sum_valid}, 64'd0);
    repeat (3) @(negedge clk);
    check64("cnt0_no_add", 64'(op_idx), 64'd0);
    check64("cnt0_pulses", 64'(sv_count - sv_before), 64'd1);

    // held add_done level must not complete the second add
    ad_mode = MODE_HOLD;
    ad_lat_max = 2;
    elems[0] = 64'h3FF0000000000000;
    elems[1] = 64'h4000000000000000;
    run_accum(2, 0, 1'b0, 64'h4008000000000000, "hold");
    repeat (12) @(negedge clk);
    ad_mode = MODE_PULSE;

    // randomized against a fold over real arithmetic
    ad_lat_max = 4;
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 6);
      r = 0.0;
      for (int i = 0; i < n; i++) begin
        elems[i] = $realtobits(real'(int'($urandom_range(0, 2000)) - 1000) / 8.0);
        r = r + $bitstoreal(elems[i]);
      end
      run_accum(n, 3, 1'($urandom_range(0, 1)), $realtobits(r), $sformatf("rnd%0d", k));
    end

    // maximum count: 255 x 1.0 = 255.0
    ad_lat_max = 1;
    for (int i = 0; i < 255; i++) elems[i] = 64'h3FF0000000000000;
    run_accum(255, 0, 1'b0, 64'h406FE00000000000, "max_count");

    // adder stops answering after the first add: timeout, partial sum kept
    ad_mode = MODE_FIRST_ONLY;
    ad_lat_max = 2;
    elems[0] = 64'h3FF0000000000000;
    elems[1] = 64'h4000000000000000;
    run_accum(2, 0, 1'b0, 64'h3FF0000000000000, "timeout");
    check64("timeout_err", {63'd0, err}, 64'd1);
    check64("timeout_issue_len", 64'(last_issue_len), 64'(TMO));
    ad_mode = MODE_PULSE;

    // reset during the second ISSUE
    ad_lat_max = 6;
    op_idx = 0;
    op_q.push_back({64'h0, 64'h3FF0000000000000});
    op_q.push_back({64'h3FF0000000000000, 64'h4000000000000000});
    sv_before = sv_count;
    start = 1'b1;
    count = CNT_W'(3);
    @(negedge clk);
    start = 1'b0;
    check64("start_clears_err", {63'd0, err}, 64'd0);
    feed(64'h3FF0000000000000, 0, 1'b0);
    feed(64'h4000000000000000, 0, 1'b0);
    check64("mid_issue_add_ready", {60'd0, add_ready}, 64'd1);
    #2 rset = 1'b0;
    #1;
    check64("arst_add_ready", {60'd0, add_ready}, 64'd0);
    check64("arst_busy", {63'd0, busy}, 64'd0);
    check64("arst_in_ready", {63'd0, in_ready}, 64'd0);
    check64("arst_sum_valid", {63'd0, sum_valid}, 64'd0);
    check64("arst_sum_z", sum_z, 64'd0);
    check64("arst_add_a", add_a, 64'd0);
    check64("arst_add_b", add_b, 64'd0);
    check64("arst_err", {63'd0, err}, 64'd0);
    check64("arst_ops_issued", 64'(op_q.size()), 64'd0);
    op_q.delete();
    repeat (2) @(negedge clk);
    rset = 1'b1;
    repeat (2) @(negedge clk);
    check64("arst_no_sum_valid", 64'(sv_count - sv_before), 64'd0);
    elems[0] = 64'h4014000000000000;
    run_accum(1, 1, 1'b0, 64'h4014000000000000, "after_reset");

    check64("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
